// File: rtl/z80fi_insn_capture.sv
// z80fi trace capture: gathers the opcode bytes of one instruction, snapshots the
// registers at start and at retirement, and emits one registered record per instruction.
module z80fi_insn_capture #(
    parameter int unsigned MAX_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   insn_start,
    input  logic                   fetch_valid,
    input  logic [7:0]             fetch_byte,
    input  logic                   insn_done,
    input  logic [15:0]            cpu_reg_ip,
    input  logic [7:0]             cpu_reg_a,
    input  logic [7:0]             cpu_reg_b,
    input  logic [7:0]             cpu_reg_c,
    input  logic [7:0]             cpu_reg_d,
    input  logic [7:0]             cpu_reg_e,
    input  logic [7:0]             cpu_reg_h,
    input  logic [7:0]             cpu_reg_l,
    output logic                   z80fi_valid,
    output logic [8*MAX_LEN-1:0]   z80fi_insn,
    output logic [2:0]             z80fi_insn_len,
    output logic [15:0]            z80fi_reg_ip_in,
    output logic [15:0]            z80fi_reg_ip_out,
    output logic [7:0]             z80fi_reg_a_in,
    output logic [7:0]             z80fi_reg_b_in,
    output logic [7:0]             z80fi_reg_c_in,
    output logic [7:0]             z80fi_reg_d_in,
    output logic [7:0]             z80fi_reg_e_in,
    output logic [7:0]             z80fi_reg_h_in,
    output logic [7:0]             z80fi_reg_l_in,
    output logic [7:0]             z80fi_reg_a_out,
    output logic [7:0]             z80fi_reg_b_out,
    output logic [7:0]             z80fi_reg_c_out,
    output logic [7:0]             z80fi_reg_d_out,
    output logic [7:0]             z80fi_reg_e_out,
    output logic [7:0]             z80fi_reg_h_out,
    output logic [7:0]             z80fi_reg_l_out,
    output logic                   z80fi_err
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    typedef struct packed {
        logic [15:0] ip;
        logic [7:0]  a, b, c, d, e, h, l;
    } regs_t;

    localparam logic [2:0] MaxCnt = 3'(MAX_LEN);

    state_e               r_state, w_state_next;
    logic [8*MAX_LEN-1:0] r_buf, w_buf_next, w_buf_fin, w_first_buf;
    logic [2:0]           r_cnt, w_cnt_next, w_cnt_fin, w_first_cnt;
    logic                 r_ovf, w_ovf_next, w_ovf_fin;
    regs_t                r_snap, w_snap_next, w_live;
    logic                 r_valid, w_valid_next, r_err, w_err_next, w_rec_load;
    logic [8*MAX_LEN-1:0] r_insn;
    logic [2:0]           r_len;
    regs_t                r_rec_in, r_rec_out;

    assign w_live = {cpu_reg_ip, cpu_reg_a, cpu_reg_b, cpu_reg_c, cpu_reg_d,
                     cpu_reg_e, cpu_reg_h, cpu_reg_l};

    // Buffer contents as they stand once this cycle's fetch byte (if any) is appended.
    always_comb begin
        w_buf_fin   = r_buf;
        w_cnt_fin   = r_cnt;
        w_ovf_fin   = r_ovf;
        w_first_buf = '0;
        w_first_cnt = 3'd0;
        if (fetch_valid) begin
            w_first_buf[7:0] = fetch_byte;
            w_first_cnt      = 3'd1;
            if (r_cnt < MaxCnt) begin
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    if (r_cnt == 3'(i)) w_buf_fin[8*i +: 8] = fetch_byte;
                end
                w_cnt_fin = r_cnt + 3'd1;
            end else begin
                w_ovf_fin = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_buf_next   = r_buf;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        w_snap_next  = r_snap;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        w_rec_load   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (insn_start) begin
                    w_state_next = StCollect;
                    w_snap_next  = w_live;
                    w_buf_next   = w_first_buf;
                    w_cnt_next   = w_first_cnt;
                    w_ovf_next   = 1'b0;
                end else if (insn_done) begin
                    w_err_next = 1'b1;
                end
            end
            StCollect: begin
                if (insn_done) begin
                    if (w_cnt_fin != 3'd0 && !w_ovf_fin) begin
                        w_valid_next = 1'b1;
                        w_rec_load   = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                    // Back-to-back: the same-cycle fetch byte went to the retiring insn.
                    if (insn_start) begin
                        w_snap_next = w_live;
                        w_buf_next  = '0;
                        w_cnt_next  = 3'd0;
                        w_ovf_next  = 1'b0;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else if (insn_start) begin
                    w_err_next  = 1'b1;
                    w_snap_next = w_live;
                    w_buf_next  = w_first_buf;
                    w_cnt_next  = w_first_cnt;
                    w_ovf_next  = 1'b0;
                end else begin
                    w_buf_next = w_buf_fin;
                    w_cnt_next = w_cnt_fin;
                    w_ovf_next = w_ovf_fin;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_buf     <= '0;
            r_cnt     <= 3'd0;
            r_ovf     <= 1'b0;
            r_snap    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_insn    <= '0;
            r_len     <= 3'd0;
            r_rec_in  <= '0;
            r_rec_out <= '0;
        end else begin
            r_state <= w_state_next;
            r_buf   <= w_buf_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            r_snap  <= w_snap_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
            if (w_rec_load) begin
                r_insn    <= w_buf_fin;
                r_len     <= w_cnt_fin;
                r_rec_in  <= r_snap;
                r_rec_out <= w_live;
            end
        end
    end

    assign z80fi_valid      = r_valid;
    assign z80fi_err        = r_err;
    assign z80fi_insn       = r_insn;
    assign z80fi_insn_len   = r_len;
    assign z80fi_reg_ip_in  = r_rec_in.ip;
    assign z80fi_reg_a_in   = r_rec_in.a;
    assign z80fi_reg_b_in   = r_rec_in.b;
    assign z80fi_reg_c_in   = r_rec_in.c;
    assign z80fi_reg_d_in   = r_rec_in.d;
    assign z80fi_reg_e_in   = r_rec_in.e;
    assign z80fi_reg_h_in   = r_rec_in.h;
    assign z80fi_reg_l_in   = r_rec_in.l;
    assign z80fi_reg_ip_out = r_rec_out.ip;
    assign z80fi_reg_a_out  = r_rec_out.a;
    assign z80fi_reg_b_out  = r_rec_out.b;
    assign z80fi_reg_c_out  = r_rec_out.c;
    assign z80fi_reg_d_out  = r_rec_out.d;
    assign z80fi_reg_e_out  = r_rec_out.e;
    assign z80fi_reg_h_out  = r_rec_out.h;
    assign z80fi_reg_l_out  = r_rec_out.l;

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Scoreboard bench for z80fi_insn_capture: a behavioural model queues the expected record
// or error per retirement; a negedge monitor compares each DUT output cycle against it.
module tb_z80fi_insn_capture;

    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [71:0] rin;
        logic [71:0] rout;
    } rec_t;

    typedef struct {
        int   cyc;
        bit   is_err;
        rec_t rec;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset, insn_start, fetch_valid, insn_done;
    logic [7:0]  fetch_byte;
    logic [15:0] ip;
    logic [7:0]  ra, rb, rc, rd, re, rh, rl;
    logic        z80fi_valid, z80fi_err;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] ip_in, ip_out;
    logic [7:0]  a_in, b_in, c_in, d_in, e_in, h_in, l_in;
    logic [7:0]  a_out, b_out, c_out, d_out, e_out, h_out, l_out;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    ev_t  sb[$];
    ev_t  cur;
    rec_t obs;

    bit          m_collect = 1'b0;
    bit          m_ovf;
    logic [31:0] m_insn;
    int          m_len;
    logic [71:0] m_snap;
    rec_t        m_last;

    z80fi_insn_capture #(.MAX_LEN(4)) dut (
        .clk(clk), .reset(reset), .insn_start(insn_start), .fetch_valid(fetch_valid),
        .fetch_byte(fetch_byte), .insn_done(insn_done),
        .cpu_reg_ip(ip), .cpu_reg_a(ra), .cpu_reg_b(rb), .cpu_reg_c(rc), .cpu_reg_d(rd),
        .cpu_reg_e(re), .cpu_reg_h(rh), .cpu_reg_l(rl),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(ip_in), .z80fi_reg_ip_out(ip_out),
        .z80fi_reg_a_in(a_in), .z80fi_reg_b_in(b_in), .z80fi_reg_c_in(c_in),
        .z80fi_reg_d_in(d_in), .z80fi_reg_e_in(e_in), .z80fi_reg_h_in(h_in),
        .z80fi_reg_l_in(l_in),
        .z80fi_reg_a_out(a_out), .z80fi_reg_b_out(b_out), .z80fi_reg_c_out(c_out),
        .z80fi_reg_d_out(d_out), .z80fi_reg_e_out(e_out), .z80fi_reg_h_out(h_out),
        .z80fi_reg_l_out(l_out),
        .z80fi_err(z80fi_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {z80fi_insn, z80fi_insn_len,
                  ip_in, a_in, b_in, c_in, d_in, e_in, h_in, l_in,
                  ip_out, a_out, b_out, c_out, d_out, e_out, h_out, l_out};

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input bit is_err);
        ev_t ev;
        ev.cyc    = cyc + 1;
        ev.is_err = is_err;
        ev.rec    = m_last;
        sb.push_back(ev);
    endtask

    task automatic model_restart(input bit fv, input logic [7:0] by, input logic [71:0] live);
        m_snap = live;
        m_ovf  = 1'b0;
        m_insn = fv ? {24'h0, by} : 32'h0;
        m_len  = fv ? 1 : 0;
    endtask

    task automatic model_append(input logic [7:0] by);
        if (m_len < 4) begin
            m_insn = m_insn | (32'(by) << (8 * m_len));
            m_len  = m_len + 1;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Update the model for one input cycle, then present it to the DUT for one edge.
    task automatic drive(input bit rs, input bit st, input bit fv, input logic [7:0] by,
                         input bit dn);
        logic [71:0] live;
        live = {ip, ra, rb, rc, rd, re, rh, rl};
        if (rs) begin
            m_collect = 1'b0;
            m_last    = '0;
        end else if (!m_collect) begin
            if (st) begin
                m_collect = 1'b1;
                model_restart(fv, by, live);
            end else if (dn) begin
                push(1'b1);
            end
        end else if (dn) begin
            if (fv) model_append(by);
            if (m_len > 0 && !m_ovf) begin
                m_last.insn = m_insn;
                m_last.len  = 3'(m_len);
                m_last.rin  = m_snap;
                m_last.rout = live;
                push(1'b0);
            end else begin
                push(1'b1);
            end
            if (st) model_restart(1'b0, 8'h00, live);
            else    m_collect = 1'b0;
        end else if (st) begin
            push(1'b1);
            model_restart(fv, by, live);
        end else if (fv) begin
            model_append(by);
        end
        reset = rs; insn_start = st; fetch_valid = fv; fetch_byte = by; insn_done = dn;
        @(posedge clk);
        #1;
        reset = 1'b0; insn_start = 1'b0; fetch_valid = 1'b0; fetch_byte = 8'h00;
        insn_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    cur = sb.pop_front();
                    check("kind", {z80fi_valid, z80fi_err}, cur.is_err ? 2'b01 : 2'b10);
                    check("rec", obs, cur.rec);
                end else begin
                    check("quiet", {z80fi_valid, z80fi_err}, 2'b00);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; insn_start = 1'b0; fetch_valid = 1'b0; fetch_byte = 8'h00;
        insn_done = 1'b0;
        ip = 16'h0000; ra = 8'h01; rb = 8'h02; rc = 8'h03; rd = 8'h04; re = 8'h05;
        rh = 8'h06; rl = 8'h07;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_rec", obs, '0);
        check("rst_flags", {z80fi_valid, z80fi_err}, 2'b00);
        mon_en = 1'b1;
        idle(2);

        // LD B,C
        ip = 16'h0100; rb = 8'h11; rc = 8'h22;
        drive(1'b0, 1'b1, 1'b1, 8'h41, 1'b0);
        ip = 16'h0101; rb = 8'h22;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ldbc_valid", z80fi_valid, 1'b1);
        check("ldbc_insn", z80fi_insn, 32'h0000_0041);
        check("ldbc_len", z80fi_insn_len, 3'd1);
        check("ldbc_ip", {ip_in, ip_out}, {16'h0100, 16'h0101});
        check("ldbc_b", {b_in, b_out}, {8'h11, 8'h22});
        idle(1);
        check("ldbc_pulse", z80fi_valid, 1'b0);

        // LD HL,0x1234 with gaps between bytes
        ip = 16'h0200;
        drive(1'b0, 1'b1, 1'b1, 8'h21, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 8'h34, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b1, 8'h12, 1'b0);
        idle(1);
        ip = 16'h0203; rh = 8'h12; rl = 8'h34;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ldhl_insn", z80fi_insn, 32'h0012_3421);
        check("ldhl_len", z80fi_insn_len, 3'd3);
        check("ldhl_hl", {h_out, l_out}, 16'h1234);
        idle(2);

        // Back-to-back: LD B,n whose last byte arrives with done+start, then LD A,B
        ip = 16'h0300;
        drive(1'b0, 1'b1, 1'b1, 8'h06, 1'b0);
        ip = 16'h0302; rb = 8'h55;
        drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        check("b2b_first_insn", {z80fi_insn, z80fi_insn_len}, {32'h0000_5506, 3'd2});
        drive(1'b0, 1'b0, 1'b1, 8'h78, 1'b0);
        ip = 16'h0303; ra = 8'h55;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("b2b_second_insn", {z80fi_insn, z80fi_insn_len}, {32'h0000_0078, 3'd1});
        check("b2b_in_eq_prev_out", {ip_in, b_in}, {16'h0302, 8'h55});
        check("b2b_a_out", a_out, 8'h55);
        idle(2);

        // Exactly four bytes, the last one on the done cycle
        ip = 16'h0400;
        drive(1'b0, 1'b1, 1'b1, 8'hDD, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h36, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
        ip = 16'h0404;
        drive(1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
        check("len4_insn", {z80fi_insn, z80fi_insn_len}, {32'h9905_36DD, 3'd4});
        idle(1);

        // Five bytes overflow: error, previous record held
        drive(1'b0, 1'b1, 1'b1, 8'hDD, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hCB, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h06, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h07, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_flags", {z80fi_valid, z80fi_err}, 2'b01);
        check("ovf_hold", {z80fi_insn, z80fi_insn_len, ip_out}, {32'h9905_36DD, 3'd4, 16'h0404});
        idle(1);

        // Start without any fetch byte, then done: zero-length error
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("len0_flags", {z80fi_valid, z80fi_err}, 2'b01);
        idle(1);

        // Protocol errors: done in IDLE, then restart during COLLECT
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("idle_done_err", {z80fi_valid, z80fi_err}, 2'b01);
        ip = 16'h0500;
        drive(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        ip = 16'h0501; ra = 8'h55;
        drive(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
        check("restart_err", {z80fi_valid, z80fi_err}, 2'b01);
        ip = 16'h0502; ra = 8'h56;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("restart_rec", {z80fi_insn, z80fi_insn_len, ip_in, a_in, a_out},
              {32'h0000_003C, 3'd1, 16'h0501, 8'h55, 8'h56});
        idle(1);

        // Reset mid-COLLECT, then an orphan done
        drive(1'b0, 1'b1, 1'b1, 8'h21, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h34, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("midrst_rec", obs, '0);
        check("midrst_flags", {z80fi_valid, z80fi_err}, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("orphan_done", {z80fi_valid, z80fi_err, z80fi_insn}, {2'b01, 32'h0});
        idle(3);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/z80fi_insn_capture.md
# z80fi_insn_capture

Trace-capture stage placed between the Z80 core and the z80fi instruction-spec checkers. Collects an instruction's opcode bytes as the core fetches them, and snapshots the architectural registers at instruction start and at retirement. On retirement it presents one registered z80fi record (`z80fi_valid` pulse plus instruction, length and in/out register values). That record is what every `z80fi_insn_spec_*` checker consumes.

## Interface

Parameters:
- `MAX_LEN`, 4: maximum instruction length in bytes. It sets the `z80fi_insn` width as 8*`MAX_LEN`. Fixed at 4 for Z80.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `insn_start`  input  1  core begins the M1 fetch of a new instruction (first opcode byte).
- `fetch_valid`  input  1  `fetch_byte` is an instruction byte (opcode, prefix, displacement or immediate) fetched this cycle.
- `fetch_byte`  input  8  instruction byte.
- `insn_done`  input  1  core retires the current instruction this cycle; register inputs hold post-instruction values.
- `cpu_reg_ip`  input  16  live program counter.
- `cpu_reg_a`, `cpu_reg_b`, `cpu_reg_c`, `cpu_reg_d`, `cpu_reg_e`, `cpu_reg_h`, `cpu_reg_l`  input  8 each  live registers.
- `z80fi_valid`  output  1  one-cycle record-valid strobe.
- `z80fi_insn`  output  32  instruction bytes; first fetched byte in [7:0]; unused bytes zero.
- `z80fi_insn_len`  output  3  byte count, 1..4.
- `z80fi_reg_ip_in`, `z80fi_reg_ip_out`  output  16  PC at start / retirement.
- `z80fi_reg_{a,b,c,d,e,h,l}_in`, `z80fi_reg_{a,b,c,d,e,h,l}_out`  output  8 each  registers at start / retirement.
- `z80fi_err`  output  1  one-cycle strobe: protocol violation; record discarded.

## Operation

- States: IDLE, COLLECT. Reset → IDLE.
- Working registers: byte buffer (32 b), count (3 b), overflow flag, in-snapshot (IP + 7 regs).
- IDLE, `insn_start`=1:
  - Latch all `cpu_reg_*` into the in-snapshot.
  - Clear buffer, count and overflow.
  - Go to COLLECT.
  - If `fetch_valid` is also 1, store `fetch_byte` as byte 0 and set count=1.
- IDLE, `insn_done`=1 (without start): pulse `z80fi_err`; no record.
- COLLECT, `fetch_valid`=1:
  - If count<4, write the byte to buffer[8*count +: 8] and increment count.
  - If count==4, set overflow; the byte is dropped; count saturates at 4.
- COLLECT, `insn_done`=1:
  - A `fetch_valid` byte in the same cycle is included first.
  - If final count≥1 and not overflow: next cycle `z80fi_valid`=1. Outputs are buffer, count, in-snapshot, and the `cpu_reg_*` values sampled this cycle as `_out`.
  - If final count==0 or overflow: next cycle `z80fi_err`=1, `z80fi_valid`=0.
  - Go to IDLE, unless `insn_start` is also 1.
- `insn_done` and `insn_start` in the same cycle (back-to-back):
  - Retire the current instruction as above.
  - Simultaneously start the new one: its in-snapshot equals the retiring `_out` values.
  - A same-cycle `fetch_valid` byte belongs to the retiring instruction, never to the new one.
  - Stay in COLLECT.
- COLLECT, `insn_start` without `insn_done`: abandon the current instruction, pulse `z80fi_err` next cycle, and restart collection (snapshot, clear) per the IDLE rule.
- Record outputs (`z80fi_insn`, `_len`, `_in`, `_out`) are registered. They hold their last values until the next valid record, and change only on the cycle `z80fi_valid` rises.

## Timing

- Latency: `insn_done` at cycle N → `z80fi_valid` (or `z80fi_err`) high in cycle N+1 only.
- `z80fi_valid` is never high in two consecutive cycles unless `insn_done` was high in two consecutive cycles, with a start between them.
- Reset at any point, including mid-COLLECT or the cycle after `insn_done`:
  - Next cycle state = IDLE and all outputs are 0: `z80fi_valid`, `z80fi_err`, `z80fi_insn`=0, `z80fi_insn_len`=0, all `_in`/`_out`=0.
  - A pending record is discarded.
- Inputs are sampled only on rising `clk`. No combinational path from inputs to outputs.

## Test plan

- Single-byte LD B,C:
  - Stimulus: start+fetch 0x41 with IP=0x0100, B=0x11, C=0x22; next cycle done with IP=0x0101, B=0x22.
  - Required: valid 1 cycle later, insn=0x00000041, len=1, ip_in=0x0100, ip_out=0x0101, b_in=0x11, b_out=0x22.
- Three-byte LD HL,0x1234:
  - Stimulus: bytes 0x21, 0x34, 0x12 over 3 non-adjacent cycles, then done.
  - Required: insn=0x00123421, len=3.
- Back-to-back:
  - Stimulus: done+start same cycle, then a second 1-byte instruction 0x78.
  - Required: two valid pulses; second record's `_in` equals first record's `_out`.
- Overflow:
  - Stimulus: 5 fetch bytes, then done.
  - Required: err pulse, no valid, previous record outputs unchanged.
- Protocol errors:
  - Stimulus: done in IDLE; separately, start during COLLECT without done.
  - Required: err pulse each time; the restarted instruction retires correctly afterward.
- Reset mid-COLLECT:
  - Stimulus: reset after 2 bytes, then done.
  - Required: all outputs 0, no valid, and `z80fi_err` pulse for the orphan done.
